// File: rtl/sram_like_pkg.sv
// Shared definitions for the sram-like bus responder: bus widths, size codes,
// the response-queue entry type and a width helper.
package sram_like_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic              is_read;
    logic [DATA_W-1:0] data;
  } resp_t;

  // Width needed to index/count n items, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_like_slave_resp_queue.sv
// In-order response FIFO; every entry carries an age counter so the head is
// only released once it has aged the configured data latency.
module resp_queue
  import sram_like_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int DATA_LAT = 2
) (
  input  logic  clk,
  input  logic  resetn,
  input  logic  push,
  input  resp_t push_data,
  input  logic  pop,
  output logic  full,
  output logic  empty,
  output logic  head_ready,
  output resp_t head_data
);

  localparam int PTR_W = cnt_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AGE_W = cnt_width(DATA_LAT);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [AGE_W-1:0] AGE_INIT  = AGE_W'(DATA_LAT - 1);

  resp_t            entry_q [DEPTH];
  logic [AGE_W-1:0] age_q   [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  assign full       = (count_q == DEPTH_CNT);
  assign empty      = (count_q == '0);
  assign head_data  = entry_q[rd_ptr_q];
  assign head_ready = !empty && (age_q[rd_ptr_q] == '0);

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Stale ages in free slots are harmless: a push always reloads its slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr_q == PTR_W'(i))) age_q[i] <= AGE_INIT;
        else if (age_q[i] != '0)             age_q[i] <= age_q[i] - 1'b1;
      end
    end
  end

  // NOTE: payload storage is deliberately not reset; validity comes from the
  // reset pointers/count, and leaving it out keeps it RAM-mappable.
  always_ff @(posedge clk) begin
    if (push) entry_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sram_like_slave.sv
// Responder end of the sram-like CPU bus: word-addressed memory, one accept
// per cycle, in-order responses after a fixed latency, optional accept gaps.
module sram_like_slave
  import sram_like_pkg::*;
#(
  parameter int AW       = 12,
  parameter int DATA_LAT = 2,
  parameter int DEPTH    = 4,
  parameter int ADDR_GAP = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              addr_ok,
  output logic [ADDR_W-1:0] addr_ok_addr,
  output logic              data_ok,
  output logic [DATA_W-1:0] rdata
);

  localparam int WORDS = 1 << AW;
  localparam int GAP_W = cnt_width(ADDR_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(ADDR_GAP);

  logic [DATA_W-1:0] mem [WORDS];
  logic [AW-1:0]     word_idx;
  logic              ready_q;
  logic [GAP_W-1:0]  gap_q;
  logic              accept;
  logic              q_full;
  logic              q_empty;
  logic              q_head_ready;
  resp_t             push_entry;
  resp_t             head_entry;
  logic              unused_ok;

  // size is informational and the byte offset is irrelevant to a word memory.
  assign unused_ok = ^{size, addr[ADDR_W-1:AW+2], addr[1:0], q_empty};

  assign word_idx = addr[AW+1:2];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which is what would otherwise infer a latch.
  always_comb begin
    accept       = 1'b0;
    addr_ok_addr = '0;
    if (req && !q_full && (gap_q == '0) && ready_q) begin
      accept       = 1'b1;
      addr_ok_addr = addr;
    end
  end

  assign addr_ok = accept;

  // Async read sees a write committed on the previous edge, giving the
  // write-then-read visibility without a bypass path.
  assign push_entry = resp_t'{is_read: !wr, data: mem[word_idx]};

  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // ready_q holds accepts off for the first cycle after reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      gap_q   <= '0;
      data_ok <= 1'b0;
      rdata   <= '0;
    end else begin
      ready_q <= 1'b1;
      if (accept)              gap_q <= GAP_INIT;
      else if (gap_q != '0)    gap_q <= gap_q - 1'b1;
      data_ok <= q_head_ready;
      rdata   <= (q_head_ready && head_entry.is_read) ? head_entry.data : '0;
    end
  end

  resp_queue #(
    .DEPTH    (DEPTH),
    .DATA_LAT (DATA_LAT)
  ) u_resp_queue (
    .clk        (clk),
    .resetn     (resetn),
    .push       (accept),
    .push_data  (push_entry),
    .pop        (q_head_ready),
    .full       (q_full),
    .empty      (q_empty),
    .head_ready (q_head_ready),
    .head_data  (head_entry)
  );

endmodule

// File: tb/tb_sram_like_slave.sv
// Directed bench for sram_like_slave: three instances cover the default
// configuration, a long-latency/full-queue case and an address-gap case.
module tb_sram_like_slave;
  import sram_like_pkg::*;

  localparam int N = 3;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  logic [N-1:0]       req;
  logic [N-1:0]       wr;
  logic [N-1:0][1:0]  size;
  logic [N-1:0][3:0]  wstrb;
  logic [N-1:0][31:0] addr;
  logic [N-1:0][31:0] wdata;
  wire  [N-1:0]       addr_ok;
  wire  [N-1:0]       data_ok;
  wire  [N-1:0][31:0] addr_ok_addr;
  wire  [N-1:0][31:0] rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Instance 0: defaults. Instance 1: DATA_LAT=4. Instance 2: ADDR_GAP=2.
  for (genvar g = 0; g < N; g++) begin : g_dut
    sram_like_slave #(
      .AW       (12),
      .DATA_LAT ((g == 1) ? 4 : 2),
      .DEPTH    (4),
      .ADDR_GAP ((g == 2) ? 2 : 0)
    ) u_dut (
      .clk          (clk),
      .resetn       (resetn),
      .req          (req[g]),
      .wr           (wr[g]),
      .size         (size[g]),
      .wstrb        (wstrb[g]),
      .addr         (addr[g]),
      .wdata        (wdata[g]),
      .addr_ok      (addr_ok[g]),
      .addr_ok_addr (addr_ok_addr[g]),
      .data_ok      (data_ok[g]),
      .rdata        (rdata[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One complete transaction on instance d; called at posedge+1.
  task automatic do_req(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        input logic [31:0] exp, input int lat, input string tag);
    int waited;
    int got_lat;
    req[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = wd; wstrb[d] = st; size[d] = SIZE_WORD;
    waited = 0;
    @(negedge clk);
    while (!addr_ok[d] && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_accept"}, 32'(addr_ok[d]), 32'd1);
    check({tag, "_ok_addr"}, addr_ok_addr[d], a);
    @(posedge clk); #1;
    req[d] = 1'b0; wr[d] = 1'b0;
    got_lat = 0;
    for (int k = 1; k <= 20 && got_lat == 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (data_ok[d]) got_lat = k;
    end
    check({tag, "_latency"}, 32'(got_lat), 32'(lat));
    check({tag, "_rdata"}, rdata[d], exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ok [8] = '{1, 1, 1, 1, 0, 1, 1, 1};
    int exp_gap[6] = '{1, 0, 0, 1, 0, 0};
    logic [31:0] resp_q[$];
    logic acc;
    int n_acc;
    int stray;

    req = '0; wr = '0; size = '0; wstrb = '0; addr = '0; wdata = '0;
    req[0] = 1'b1;

    // Reset state, including no accept while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_addr_ok", 32'(addr_ok[0]), 32'd0);
    check("rst_data_ok", 32'(data_ok[0]), 32'd0);
    check("rst_rdata", rdata[0], 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("rst_first_cycle_aok", 32'(addr_ok[0]), 32'd0);
    @(posedge clk); #1;
    req[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Test 1: back-to-back write then read of the same word.
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h100; wdata[0] = 32'hDEADBEEF; wstrb[0] = 4'hF;
    @(negedge clk);
    check("t1_wr_accept", 32'(addr_ok[0]), 32'd1);
    @(posedge clk); #1;
    wr[0] = 1'b0;
    @(negedge clk);
    check("t1_rd_accept", 32'(addr_ok[0]), 32'd1);
    check("t1_dok_c1", 32'(data_ok[0]), 32'd0);
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    check("t1_dok_c2", 32'(data_ok[0]), 32'd0);
    @(posedge clk); @(negedge clk);
    check("t1_wr_resp_dok", 32'(data_ok[0]), 32'd1);
    check("t1_wr_resp_rdata", rdata[0], 32'd0);
    @(posedge clk); @(negedge clk);
    check("t1_rd_resp_dok", 32'(data_ok[0]), 32'd1);
    check("t1_rd_resp_rdata", rdata[0], 32'hDEADBEEF);
    @(posedge clk); @(negedge clk);
    check("t1_dok_after", 32'(data_ok[0]), 32'd0);
    @(posedge clk); #1;

    // Test 2: partial byte-strobe write merges into an existing word.
    do_req(0, 1'b1, 32'h20, 32'h11223344, 4'hF,    32'd0,         2, "t2_full_wr");
    do_req(0, 1'b1, 32'h20, 32'h0000AA00, 4'b0010, 32'd0,         2, "t2_strb_wr");
    do_req(0, 1'b0, 32'h20, 32'd0,        4'h0,    32'h1122AA44,  2, "t2_rd");

    // Test 6: upper address bits ignored.
    do_req(0, 1'b1, 32'h4,    32'hCAFEF00D, 4'hF, 32'd0,        2, "t6_wr");
    do_req(0, 1'b0, 32'h4004, 32'd0,        4'h0, 32'hCAFEF00D, 2, "t6_wrap_rd");
    do_req(0, 1'b0, 32'h4,    32'd0,        4'h0, 32'hCAFEF00D, 2, "t6_direct_rd");

    // Test 3: fill the queue with DATA_LAT=4; words 0x200+4i hold i.
    for (int i = 0; i < 7; i++)
      do_req(1, 1'b1, 32'h200 + 32'(4 * i), 32'(i), 4'hF, 32'd0, 4, $sformatf("t3_pre%0d", i));
    n_acc = 0;
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h200;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("t3_aok_c%0d", c), 32'(addr_ok[1]), 32'(exp_ok[c]));
      if (data_ok[1]) resp_q.push_back(rdata[1]);
      acc = addr_ok[1];
      @(posedge clk); #1;
      if (acc) begin
        n_acc++;
        addr[1] = 32'h200 + 32'(4 * n_acc);
      end
    end
    req[1] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (data_ok[1]) resp_q.push_back(rdata[1]);
      @(posedge clk); #1;
    end
    check("t3_accepts", 32'(n_acc), 32'd7);
    check("t3_responses", 32'(resp_q.size()), 32'd7);
    for (int i = 0; i < resp_q.size(); i++)
      check($sformatf("t3_order%0d", i), resp_q[i], 32'(i));

    // Test 4: ADDR_GAP=2 throttles accepts to one in three cycles.
    req[2] = 1'b1; wr[2] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      addr[2] = 32'h300 + 32'(4 * c);
      @(negedge clk);
      check($sformatf("t4_aok_c%0d", c), 32'(addr_ok[2]), 32'(exp_gap[c]));
      check($sformatf("t4_okaddr_c%0d", c), addr_ok_addr[2],
            (exp_gap[c] != 0) ? 32'h300 + 32'(4 * c) : 32'd0);
      @(posedge clk); #1;
    end
    req[2] = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Test 5: reset drops pending reads on instance 1 (DATA_LAT=4).
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h210;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("t5_accept%0d", c), 32'(addr_ok[1]), 32'd1);
      check($sformatf("t5_no_dok%0d", c), 32'(data_ok[1]), 32'd0);
      @(posedge clk); #1;
      addr[1] = addr[1] + 32'd4;
    end
    req[1] = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    check("t5_rst_dok", 32'(data_ok[1]), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1; req[1] = 1'b1; addr[1] = 32'h20C;
    @(negedge clk);
    check("t5_first_cycle_aok", 32'(addr_ok[1]), 32'd0);
    @(posedge clk); #1;
    req[1] = 1'b0;
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (data_ok[1]) stray++;
      @(posedge clk); #1;
    end
    check("t5_dropped", 32'(stray), 32'd0);
    do_req(1, 1'b0, 32'h218, 32'd0, 4'h0, 32'd6, 4, "t5_new_rd");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
